uart_tx_buffered: RTL



---
 rtl/uart_tx_buffered.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding an 8N1 UART transmitter
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   TX         byte to push, sampled with start_TX
//   start_TX   push strobe, accepted when TX_ready=1
//   TX_ready   registered !full of the byte FIFO
//   serial_out UART line, idle high, driven from a flop
//   busy       frame on the line or FIFO non-empty
//   overflow   sticky, set by a push attempted while TX_ready=0
module uart_tx_buffered #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] TX,
   input  logic       start_TX,
   output logic       TX_ready,
   output logic       serial_out,
   output logic       busy,
   output logic       overflow
);
   localparam int CPB = CLK_HZ / BAUD;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int BW  = $clog2(CPB);
   generate
      if (CPB < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
         $error("uart_tx_buffered: CLKS_PER_BIT must be >= 2 and FIFO_DEPTH a power of 2 >= 2");
      end
   endgenerate
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t        state_q, state_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          ready_q, ser_q, busy_q, ovf_q;
   logic          push, pop, empty, tick;
   assign empty      = cnt_q == '0;
   assign tick       = baud_q == BW'(CPB - 1);
   assign push       = start_TX & ready_q;
   assign cnt_d      = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
   assign TX_ready   = ready_q;
   assign serial_out = ser_q;
   assign busy       = busy_q;
   assign overflow   = ovf_q;
   // IDLE and end of STOP both load the next byte, so queued frames run back to back
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_q];
               state_d = START;
            end
         end
         START: if (tick) begin
            baud_d  = '0;
            bit_d   = '0;
            state_d = DATA;
         end
         DATA: if (tick) begin
            baud_d  = '0;
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            state_d = bit_q == 3'd7 ? STOP : DATA;
         end
         default: if (tick) begin
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_q];
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= TX;
   // line and busy are registered from the current state, so they move together
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         ready_q <= 1'b1;
         ser_q   <= 1'b1;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         if (push) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         ready_q <= cnt_d != (AW+1)'(FIFO_DEPTH);
         ser_q   <= state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
         busy_q  <= state_q != IDLE || !empty;
         ovf_q   <= ovf_q | (start_TX & ~ready_q);
      end
   end
endmodule
